// File: rtl/req_pkg.sv
// Shared widths and FSM encoding for the request-capture stage feeding
// the 8-input lowest-index priority encoder.
package req_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;
endpackage

// File: rtl/req_debounce.sv
// One-bit debouncer: dout follows din only after din has differed from dout
// for DB_CYCLES consecutive cycles. dout resets high.
module req_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b1;
      cnt  <= '0;
    end else if (din != dout) begin
      if (cnt == CW'(DB_CYCLES - 1)) begin
        dout <= din;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
endmodule

// File: rtl/req_capture_ctrl.sv
// Captures rising edges on request lines and presents frozen snapshots to the
// priority encoder. Optional input debouncing is enabled by REQ_DEBOUNCE_EN.
module req_capture_ctrl
  import req_pkg::*;
`ifdef REQ_DEBOUNCE_EN
#(
  parameter int DB_CYCLES = 4
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_raw,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clr_ovf,
  output logic [N_REQ-1:0] pend,
  output logic             en_n,
  output logic             busy,
  output logic             ovf
);
  state_t           state;
  logic [N_REQ-1:0] filt, req_q, rise, pending, snap, clr;
  logic             ack_valid, ovf_set;

`ifdef REQ_DEBOUNCE_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_db
    req_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (req_raw[i]),
      .dout (filt[i])
    );
  end
`else
  assign filt = req_raw;
`endif

  assign rise      = filt & ~req_q;
  assign ack_valid = (state == PRESENT) && ack && snap[ack_idx];
  assign ovf_set   = |(rise & pending & ~clr);
  assign busy      = (|pending) || (state != IDLE);

  // Only an ack naming a bit of the presented snapshot may clear pending.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_REQ; i++)
      clr[i] = ack_valid && (ack_idx == IDX_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '1;
      pending <= '0;
      snap    <= '0;
      pend    <= '0;
      en_n    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      req_q   <= filt;
      pending <= rise | (pending & ~clr);
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;

      // Snapshots load from the registered pending value, so rises on this
      // edge wait for the next presentation.
      case (state)
        IDLE: if (|pending) begin
          state <= PRESENT;
          snap  <= pending;
          pend  <= pending;
          en_n  <= 1'b0;
        end
        PRESENT: if (ack_valid) begin
          state <= GAP;
          pend  <= '0;
          en_n  <= 1'b1;
        end
        GAP: if (|pending) begin
          state <= PRESENT;
          snap  <= pending;
          pend  <= pending;
          en_n  <= 1'b0;
        end else begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          pend  <= '0;
          en_n  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_req_capture_ctrl.sv
// Directed bench for req_capture_ctrl with an in-bench behavioural model
// checked every cycle, plus literal expectations at key points.
module tb_req_capture_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_raw = '0;
  logic       ack = 1'b0;
  logic [2:0] ack_idx = '0;
  logic       clr_ovf = 1'b0;
  logic [7:0] pend;
  logic       en_n, busy, ovf;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  req_capture_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req_raw (req_raw),
    .ack     (ack),
    .ack_idx (ack_idx),
    .clr_ovf (clr_ovf),
    .pend    (pend),
    .en_n    (en_n),
    .busy    (busy),
    .ovf     (ovf)
  );

  // Model: 0 = idle, 1 = presenting, 2 = gap.
  int       m_st = 0;
  bit [7:0] m_pnd, m_snap, m_prev, m_filt, m_old, m_rise, m_clr, m_cur;
  bit       m_ovf;
  int       m_run [8];

  initial forever begin
    @(posedge clk);
    started = 1'b1;
    if (rst) begin
      m_st = 0; m_pnd = 0; m_snap = 0; m_ovf = 0;
      m_prev = 8'hFF; m_filt = 8'hFF;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
`ifdef REQ_DEBOUNCE_EN
      m_cur = m_filt;
      for (int i = 0; i < 8; i++) begin
        if (req_raw[i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_filt[i] = req_raw[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
`else
      m_cur = req_raw;
`endif
      m_rise = m_cur & ~m_prev;
      m_prev = m_cur;
      m_clr  = 0;
      if (m_st == 1 && ack && m_snap[ack_idx]) m_clr = 8'(1 << ack_idx);
      if ((m_rise & m_pnd & ~m_clr) != 0) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_old = m_pnd;
      m_pnd = m_rise | (m_pnd & ~m_clr);
      case (m_st)
        0: if (m_old != 0) begin m_st = 1; m_snap = m_old; end
        1: if (m_clr != 0) m_st = 2;
        default: if (m_old != 0) begin m_st = 1; m_snap = m_old; end else m_st = 0;
      endcase
    end
  end

  wire [7:0] e_pend = (m_st == 1) ? m_snap : 8'h00;
  wire       e_en_n = (m_st != 1);
  wire       e_busy = (m_pnd != 0) || (m_st != 0);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("cyc_pend", pend, e_pend);
      chk("cyc_en_n", 8'(en_n), 8'(e_en_n));
      chk("cyc_busy", 8'(busy), 8'(e_busy));
      chk("cyc_ovf",  8'(ovf),  8'(m_ovf));
    end
  end

  // Literal expectations applied to both the DUT and the model.
  task automatic pin(input string nm, input logic [7:0] p, input logic e, input logic b, input logic o);
    chk({nm, "_pend"}, pend, p);
    chk({nm, "_en_n"}, 8'(en_n), 8'(e));
    chk({nm, "_busy"}, 8'(busy), 8'(b));
    chk({nm, "_ovf"},  8'(ovf),  8'(o));
    chk({nm, "_mdl_pend"}, e_pend, p);
    chk({nm, "_mdl_en_n"}, 8'(e_en_n), 8'(e));
    chk({nm, "_mdl_busy"}, 8'(e_busy), 8'(b));
    chk({nm, "_mdl_ovf"},  8'(m_ovf),  8'(o));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] v);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) lowest = 3'(i);
  endfunction

  // Acknowledge the lowest presented index until everything drains.
  task automatic serve(input int budget);
    int c = 0;
    while ((m_st != 0 || m_pnd != 0) && c < budget) begin
      if (m_st == 1) begin ack = 1'b1; ack_idx = lowest(m_snap); end
      else ack = 1'b0;
      tick();
      c++;
    end
    ack = 1'b0;
    chk("serve_in_budget", 8'(c < budget), 8'd1);
    chk("serve_idle_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    tick(2);
    pin("reset", 8'h00, 1, 0, 0);
    rst = 1'b0;
    tick();
`ifdef REQ_DEBOUNCE_EN
    tick(6);
    pin("db_settle", 8'h00, 1, 0, 0);
    req_raw = 8'h01; tick(2); req_raw = 8'h00; tick(8);
    pin("db_glitch", 8'h00, 1, 0, 0);
    req_raw = 8'h01; tick(5);
    pin("db_pulse_pend", 8'h00, 1, 1, 0);
    tick();
    pin("db_pulse_pres", 8'h01, 0, 1, 0);
    req_raw = 8'h00;
    ack = 1'b1; ack_idx = 3'd0; tick(); ack = 1'b0;
    serve(20);
    tick(8);
    pin("db_quiet", 8'h00, 1, 0, 0);
`else
    // Single request
    req_raw = 8'h08; tick();
    pin("t1_capt", 8'h00, 1, 1, 0);
    tick();
    pin("t1_pres", 8'h08, 0, 1, 0);
    ack = 1'b1; ack_idx = 3'd3; tick(); ack = 1'b0;
    pin("t1_gap", 8'h00, 1, 1, 0);
    tick();
    pin("t1_idle", 8'h00, 1, 0, 0);
    req_raw = 8'h00; tick();
    // Two requests on one edge
    req_raw = 8'h05; tick(2);
    pin("t2_pres", 8'h05, 0, 1, 0);
    ack = 1'b1; ack_idx = 3'd0; tick(); ack = 1'b0;
    pin("t2_gap", 8'h00, 1, 1, 0);
    tick();
    pin("t2_pres2", 8'h04, 0, 1, 0);
    ack = 1'b1; ack_idx = 3'd2; tick(); ack = 1'b0; tick();
    pin("t2_idle", 8'h00, 1, 0, 0);
    req_raw = 8'h00; tick();
    // Overflow and clr_ovf priority
    req_raw = 8'h02; tick(2);
    req_raw = 8'h00; tick();
    req_raw = 8'h02; tick();
    pin("t3_ovf", 8'h02, 0, 1, 1);
    tick();
    pin("t3_sticky", 8'h02, 0, 1, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    pin("t3_clr", 8'h02, 0, 1, 0);
    req_raw = 8'h00; tick();
    req_raw = 8'h02; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    pin("t3_setwins", 8'h02, 0, 1, 1);
    ack = 1'b1; ack_idx = 3'd1; tick(); ack = 1'b0; tick();
    pin("t3_idle", 8'h00, 1, 0, 1);
    clr_ovf = 1'b1; req_raw = 8'h00; tick(); clr_ovf = 1'b0; tick();
    pin("t3_cleared", 8'h00, 1, 0, 0);
    // Set wins over clear on the acked bit
    req_raw = 8'h10; tick(2);
    req_raw = 8'h00; tick();
    ack = 1'b1; ack_idx = 3'd4; req_raw = 8'h10; tick(); ack = 1'b0;
    pin("t4_gap", 8'h00, 1, 1, 0);
    tick();
    pin("t4_repres", 8'h10, 0, 1, 0);
    ack = 1'b1; ack_idx = 3'd4; tick(); ack = 1'b0; tick();
    pin("t4_idle", 8'h00, 1, 0, 0);
    // Lines held high through reset
    req_raw = 8'hFF; rst = 1'b1; tick(); rst = 1'b0; tick(3);
    pin("t4_held", 8'h00, 1, 0, 0);
    req_raw = 8'h00; tick();
    // Ignored acks and reset mid-presentation
    req_raw = 8'h01; tick(2);
    ack = 1'b1; ack_idx = 3'd6; tick();
    pin("t5_badack", 8'h01, 0, 1, 0);
    ack_idx = 3'd0; tick(); ack = 1'b0; tick();
    req_raw = 8'h00; tick();
    ack = 1'b1; ack_idx = 3'd0; tick(); ack = 1'b0;
    pin("t5_idleack", 8'h00, 1, 0, 0);
    req_raw = 8'h20; tick(2);
    pin("t5_pres", 8'h20, 0, 1, 0);
    rst = 1'b1; tick();
    pin("t5_rst", 8'h00, 1, 0, 0);
    rst = 1'b0; tick(2);
    pin("t5_after", 8'h00, 1, 0, 0);
    req_raw = 8'h00; tick();
    // Mixed vectors drained in priority order
    foreach (vecs[k]) begin
      req_raw = vecs[k]; tick(); req_raw = 8'h00;
      serve(40);
      tick();
    end
    // New rise arriving while another snapshot is presented
    req_raw = 8'h01; tick(2);
    req_raw = 8'h03;
    serve(20);
    req_raw = 8'h00; tick(2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  logic [7:0] vecs [4] = '{8'h81, 8'h3C, 8'hFF, 8'h42};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/req_capture_ctrl.md
Name: req_capture_ctrl

Overview:
Upstream stage for the 8-input lowest-index priority encoder (active-low enable, 3-bit index Y, Done flag). It captures rising edges on 8 synchronous request lines into a pending register. It presents a frozen snapshot of pending requests to the encoder's In port and drives the encoder's active-low enable. It clears the bit whose index the consumer acknowledges (the encoder's Y), then re-presents any requests still pending.

Parameters:
N_REQ, 8, number of request lines; fixed to 8 to match the encoder width.
IDX_W, 3, width of the acknowledge index.
DB_CYCLES, 4, debounce stability length in cycles; used only with REQ_DEBOUNCE_EN.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
req_raw  input  8  request lines, synchronous to clk.
ack  input  1  consumer has served the request at ack_idx.
ack_idx  input  3  index being served (encoder Y).
clr_ovf  input  1  clears the sticky overflow flag.
pend  output  8  snapshot to encoder In; 0 when not presenting.
en_n  output  1  encoder enable, active-low; 0 only in PRESENT.
busy  output  1  high if any request is pending or state != IDLE.
ovf  output  1  sticky flag: a rising edge arrived on an already-pending bit.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, pending=0, snap=0, pend=0, en_n=1, ovf=0, busy=0.
  - Edge-history register req_q is loaded with 0xFF, so lines held high through reset never generate a capture.
- Edge detect: rise = filt & ~req_q, with req_q <= filt every cycle. filt = req_raw without the optional feature.
- Pending update per bit i, every edge:
  - set_i = rise[i].
  - clr_i = (state==PRESENT && ack && ack_idx==i && snap[i]).
  - Set wins over clear: pending[i] <= set_i | (pending[i] & ~clr_i).
- Overflow:
  - Set when rise[i] && pending[i] && !clr_i for any i.
  - Cleared by clr_ovf; set wins over clr_ovf in the same cycle.
- FSM states: IDLE, PRESENT, GAP.
  - IDLE: when pending register != 0, go to PRESENT and load snap <= pending (registered value; this cycle's rises excluded).
  - PRESENT: pend=snap, en_n=0, snap held constant. On a valid ack (snap[ack_idx]==1), go to GAP.
  - PRESENT, invalid ack (ack with snap[ack_idx]==0): ignored, stay in PRESENT.
  - GAP: lasts 1 cycle with en_n=1 and pend=0. Then go to PRESENT (reloading snap from pending) if pending != 0, else IDLE.
- ack outside PRESENT is ignored.
- Latency:
  - req_raw rises before edge k: pending is set at edge k, PRESENT is entered at edge k+1, and en_n=0 during cycle k+1.
  - Valid ack at edge m: en_n=1 during cycle m (GAP); next presentation starts at edge m+1.
- All outputs are registered or decoded directly from state and snap; no combinational path from req_raw to outputs.
- A reset asserted mid-PRESENT or mid-GAP returns to the reset values on that edge; pending requests are discarded.

Optional Feature:
REQ_DEBOUNCE_EN:
- Defined: each line passes through a debouncer. filt[i] changes only after req_raw[i] differs from filt[i] for DB_CYCLES consecutive cycles. This adds DB_CYCLES cycles of capture latency. filt resets to 1 and the counters reset to 0.
- Undefined: filt=req_raw, no counters synthesized, latency as listed above.

Decomposition:
- Package req_pkg holds:
  - N_REQ=8 and IDX_W=3.
  - A state enum {IDLE, PRESENT, GAP} with 2-bit encoding.
- Natural sub-module req_debounce: a one-bit debouncer with parameter DB_CYCLES and counter width $clog2(DB_CYCLES+1). It is instantiated N_REQ times under REQ_DEBOUNCE_EN.

Test Plan:
1. Single request served: reset; req_raw 0x00 -> 0x08 -> en_n=0, pend=0x08 one cycle after capture; ack idx=3 -> GAP, then IDLE, busy=0, ovf=0.
2. Two requests in order: req_raw 0x00 -> 0x05 on the same edge -> pend=0x05; ack idx=0 -> GAP -> pend=0x04; ack idx=2 -> IDLE.
3. Overflow: bit 1 pending, req_raw bit 1 falls then rises again before ack -> ovf=1 (sticky); clr_ovf pulse -> ovf=0; clr_ovf coincident with a new overflow -> ovf stays 1.
4. Set-over-clear and held lines:
   - ack idx=4 on the same edge as a new rise on bit 4 -> pending[4] stays 1, next PRESENT shows pend=0x10, ovf=0.
   - req_raw=0xFF held through reset -> no capture.
5. Ignored acks and mid-operation reset:
   - ack idx=6 while snap=0x01 -> stays PRESENT.
   - ack in IDLE -> no effect.
   - rst during PRESENT -> next cycle en_n=1, pend=0, busy=0.
6. REQ_DEBOUNCE_EN, DB_CYCLES=4: a 2-cycle high glitch on bit 0 -> never captured; a 6-cycle high pulse -> captured, en_n=0 four cycles later than without the macro.
